adder_rr_arbiter: RTL and testbench
===================================

Name: adder_rr_arbiter

Overview:
- Shares one adder datapath (sum = x + y + cin, registered result plus zero flag) among NUM_REQ requesters using round-robin arbitration.
- Each requester offers operands on a valid/ready handshake. The single registered result is returned on one response channel, tagged with the requester index.
- Sits between multiple producer engines and the shared arithmetic resource. Replaces per-requester adder instances.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ
- WIDTH, 8, operand width
- SWIDTH, WIDTH + 1, result width (carry-out kept)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- cfg_en  input  1  1 = grants allowed; 0 = no new grants, in-flight result still drains
- req_valid  input  NUM_REQ  per-requester operand valid
- req_ready  output  NUM_REQ  per-requester grant/accept, at most one bit high
- req_x  input  NUM_REQ*WIDTH  packed x operands, requester i at [i*WIDTH +: WIDTH]
- req_y  input  NUM_REQ*WIDTH  packed y operands, same packing
- req_cin  input  NUM_REQ  per-requester carry-in
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  ID_W  index of requester that produced rsp_sum
- rsp_sum  output  SWIDTH  x + y + cin, zero-extended to SWIDTH before adding
- rsp_zero  output  1  1 when rsp_sum == 0
- busy  output  1  1 when a result is held (rsp_valid) or any req_valid is high while cfg_en=1

Behaviour:
- Reset (async assert, sync-to-clk deassert handled externally):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_zero=0.
  - Round-robin pointer ptr=0; state=IDLE.
  - req_ready=0, since it is derived from state and cfg_en.
- can_accept = cfg_en & (~rsp_valid | rsp_ready). One-entry output register with same-cycle drain-and-refill.
- Arbitration (combinational, same cycle):
  - Search req_valid starting at index ptr, ascending, wrapping modulo NUM_REQ.
  - The first set bit g wins; req_ready[g] = can_accept. All other req_ready bits are 0.
  - No req_valid set -> req_ready all 0.
- Handshake: a transfer occurs on a cycle where req_valid[g] & req_ready[g].
  - Requesters must hold operands stable while valid and not ready.
  - A requester may drop valid without a transfer; no state changes.
- On transfer:
  - Next edge: rsp_sum <= req_x[g] + req_y[g] + req_cin[g] at SWIDTH bits; rsp_zero <= (that sum == 0); rsp_id <= g; rsp_valid <= 1.
  - ptr <= (g + 1) mod NUM_REQ.
  - Latency: 1 cycle from accept to rsp_valid.
- No transfer and rsp_valid & rsp_ready: rsp_valid <= 0. rsp_sum, rsp_id and rsp_zero hold their last values.
- Transfer and rsp_ready in the same cycle: the old result is consumed and the new one is loaded. Back-to-back throughput is 1 per cycle.
- rsp_valid & ~rsp_ready: all rsp_* hold, req_ready all 0, ptr unchanged.
- ptr changes only on a transfer. An idle requester does not advance it.
- States:
  - IDLE: rsp_valid=0.
  - FULL: rsp_valid=1, rsp_ready=1 this cycle, so the result drains.
  - STALL: rsp_valid=1, rsp_ready=0.
  - Transitions follow the rules above. State is observable only through rsp_valid/req_ready; no extra encoding is required.
- cfg_en=0:
  - req_ready forced 0.
  - A held result still drains on rsp_ready.
  - ptr frozen.
  - Takes effect the same cycle it changes.
- Width rule: WIDTH-bit + WIDTH-bit + 1-bit sum, computed in SWIDTH bits. Max value 2**(WIDTH+1)-1, so it never wraps at the default SWIDTH.
- Reset mid-operation: any held result is discarded and all outputs return to reset values immediately, without waiting for clk.

Test Plan:
- Single requester: after reset, req_valid=4'b0100, x2=200, y2=100, cin2=1, rsp_ready=1 -> req_ready=4'b0100 the same cycle. Next cycle rsp_valid=1, rsp_id=2, rsp_sum=301, rsp_zero=0. ptr becomes 3.
- Round-robin fairness: all four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0,1 on consecutive cycles, one result per cycle, rsp_id following the same sequence.
- Backpressure: result pending with rsp_ready=0 for 3 cycles and req_valid=4'b1111 -> req_ready=0 and rsp_* stable for 3 cycles. On rsp_ready=1, drain and the next grant occur in the same cycle.
- Zero and carry corners: x=0, y=0, cin=0 -> rsp_sum=0, rsp_zero=1. x=255, y=255, cin=1 -> rsp_sum=511, rsp_zero=0.
- cfg_en gating: cfg_en=0 with req_valid=4'b0011 and a pending result -> the pending result drains and no grants occur for 5 cycles. cfg_en=1 -> requester at ptr is granted first.
- Async reset: assert rst_n=0 between clock edges while rsp_valid=1 -> rsp_valid=0, rsp_sum=0, req_ready=0 immediately. After release, the first grant goes to index 0.

Source files
------------

// File: rtl/adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// adder_rr_arbiter
//
// Lets NUM_REQ requesters share one adder (sum = x + y + cin). Round-robin
// arbitration decides which requester is accepted. The result sits in a
// one-entry output register and is tagged with the winning requester index.
// That register can be drained and refilled in the same cycle, so the block
// can accept one operation per clock.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous, active-low reset
//   cfg_en     1 = new grants allowed; 0 = no grants, a held result still drains
//   req_valid  [NUM_REQ]        per-requester operand valid
//   req_ready  [NUM_REQ]        per-requester accept (one-hot or zero)
//   req_x      [NUM_REQ*WIDTH]  packed x operands, requester i at [i*WIDTH +: WIDTH]
//   req_y      [NUM_REQ*WIDTH]  packed y operands, same packing
//   req_cin    [NUM_REQ]        per-requester carry-in
//   rsp_valid  result valid
//   rsp_ready  consumer accepts the result
//   rsp_id     [ID_W]           index of the requester that produced rsp_sum
//   rsp_sum    [SWIDTH]         x + y + cin, carry-out kept
//   rsp_zero   1 when rsp_sum == 0
//   busy       result held, or any request pending while cfg_en = 1
//
// ID_W must satisfy 2**ID_W >= NUM_REQ.
// -----------------------------------------------------------------------------
module adder_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int WIDTH   = 8,
    parameter int SWIDTH  = WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_x,
    input  logic [NUM_REQ*WIDTH-1:0]   req_y,
    input  logic [NUM_REQ-1:0]         req_cin,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [SWIDTH-1:0]          rsp_sum,
    output logic                       rsp_zero,
    output logic                       busy
);

    // -------------------------------------------------------------------------
    // State
    //   Only "empty" (ST_IDLE) and "holding a result" (ST_FULL) are stored.
    //   A held result either drains this cycle (rsp_ready = 1, FULL) or waits
    //   (rsp_ready = 0, STALL). That difference depends on the current
    //   rsp_ready input, so STALL is decoded combinationally into cur_state
    //   and is never written into the register.
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FULL  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    state_t              cur_state;

    logic [ID_W-1:0]     ptr_reg;
    logic [ID_W-1:0]     ptr_next;

    logic [ID_W-1:0]     rsp_id_reg;
    logic [SWIDTH-1:0]   rsp_sum_reg;
    logic                rsp_zero_reg;

    logic                can_accept;
    logic                load_en;

    // -------------------------------------------------------------------------
    // Operand unpacking
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]    x_arr [NUM_REQ];
    logic [WIDTH-1:0]    y_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign x_arr[gi] = req_x[gi*WIDTH +: WIDTH];
            assign y_arr[gi] = req_y[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin search
    //   The search starts at ptr and wraps around. This is built from two
    //   lowest-index searches:
    //     1. lowest set bit among requests at index >= ptr;
    //     2. if there is none, lowest set bit among all requests.
    //   The result matches an ascending search from ptr modulo NUM_REQ.
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0]  upper_valid;
    logic                hi_any;
    logic [ID_W-1:0]     hi_idx;
    logic                lo_any;
    logic [ID_W-1:0]     lo_idx;
    logic [ID_W-1:0]     grant_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_upper
            assign upper_valid[gi] = req_valid[gi] & (ID_W'(gi) >= ptr_reg);
        end
    endgenerate

    // The loops run downward, so the lowest matching index is the last one
    // written.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_any = 1'b0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (upper_valid[i]) begin
                hi_any = 1'b1;
                hi_idx = ID_W'(i);
            end
            if (req_valid[i]) begin
                lo_any = 1'b1;
                lo_idx = ID_W'(i);
            end
        end
    end

    assign grant_idx = hi_any ? hi_idx : lo_idx;

    // -------------------------------------------------------------------------
    // Shared datapath: select the winner's operands and feed the single adder
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]    x_sel;
    logic [WIDTH-1:0]    y_sel;
    logic                cin_sel;
    logic [SWIDTH-1:0]   sum_next;
    logic                zero_next;

    always_comb begin
        x_sel   = '0;
        y_sel   = '0;
        cin_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                x_sel   = x_arr[i];
                y_sel   = y_arr[i];
                cin_sel = req_cin[i];
            end
        end
    end

    // Operands are zero-extended before the add, so the carry-out is kept.
    assign sum_next  = SWIDTH'(x_sel) + SWIDTH'(y_sel) + SWIDTH'(cin_sel);
    assign zero_next = (sum_next == '0);

    // -------------------------------------------------------------------------
    // FSM process 1: state register (plus the arbitration pointer)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next state
    // -------------------------------------------------------------------------
    always_comb begin
        cur_state = ST_IDLE;
        if (state_reg == ST_FULL) begin
            cur_state = rsp_ready ? ST_FULL : ST_STALL;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (cur_state)
            ST_IDLE:  state_next = load_en ? ST_FULL : ST_IDLE;
            // The held result drains this cycle. A new load refills it at once.
            ST_FULL:  state_next = load_en ? ST_FULL : ST_IDLE;
            ST_STALL: state_next = ST_FULL;
            default:  state_next = ST_IDLE;
        endcase
        // The pointer moves only on a real transfer.
        if (load_en) begin
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + ID_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs / handshake
    //   Qualifying with rst_n makes req_ready drop as soon as reset is asserted,
    //   without waiting for a clock edge.
    // -------------------------------------------------------------------------
    always_comb begin
        can_accept = rst_n & cfg_en & (cur_state != ST_STALL);
        load_en    = can_accept & lo_any;
        rsp_valid  = (state_reg == ST_FULL);
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = load_en & (grant_idx == ID_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Result register. When no new load happens, the last result stays
    // visible after it drains.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_reg   <= '0;
            rsp_sum_reg  <= '0;
            rsp_zero_reg <= 1'b0;
        end else if (load_en) begin
            rsp_id_reg   <= grant_idx;
            rsp_sum_reg  <= sum_next;
            rsp_zero_reg <= zero_next;
        end
    end

    assign rsp_id   = rsp_id_reg;
    assign rsp_sum  = rsp_sum_reg;
    assign rsp_zero = rsp_zero_reg;

    assign busy = rsp_valid | (cfg_en & (|req_valid));

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for adder_rr_arbiter (NUM_REQ=4, WIDTH=8).
// A behavioural model predicts the outputs each cycle. It keeps the
// round-robin pointer as an integer, does a modulo search over the requests,
// and holds at most one outstanding result.
// -----------------------------------------------------------------------------
module tb_adder_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic            clk;
    logic            rst_n;
    logic            cfg_en;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_x;
    logic [N*W-1:0]  req_y;
    logic [N-1:0]    req_cin;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [W:0]      rsp_sum;
    logic            rsp_zero;
    logic            busy;

    adder_rr_arbiter #(
        .NUM_REQ (N),
        .ID_W    (2),
        .WIDTH   (W),
        .SWIDTH  (W + 1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int      m_ptr;
    bit      m_valid;
    int      m_id;
    int      m_sum;
    bit      m_zero;
    int      grants[$];
    logic [N-1:0] last_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_id    = 0;
        m_sum   = 0;
        m_zero  = 0;
    endtask

    task automatic check_rsp();
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_id",    32'(rsp_id),    32'(m_id));
        chk("rsp_sum",   32'(rsp_sum),   32'(m_sum));
        chk("rsp_zero",  32'(rsp_zero),  32'(m_zero));
    endtask

    // Call this at a negedge, after the inputs have been driven. It checks the
    // handshake, moves through one rising edge, and checks the result at the
    // next negedge.
    task automatic cycle();
        int           g;
        int           s;
        bit           can;
        logic [N-1:0] exp_rdy;
        #1;
        g   = model_grant();
        can = cfg_en && (!m_valid || rsp_ready);
        exp_rdy = '0;
        s = 0;
        if (g >= 0 && can) begin
            exp_rdy[g] = 1'b1;
            s = int'(req_x[g*W +: W]) + int'(req_y[g*W +: W]) + int'(req_cin[g]);
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(m_valid || (cfg_en && req_valid != '0)));
        last_rdy = exp_rdy;
        @(posedge clk);
        if (exp_rdy != '0) begin
            m_valid = 1;
            m_id    = g;
            m_sum   = s;
            m_zero  = (s == 0);
            m_ptr   = (g + 1) % N;
            grants.push_back(g);
            $display("txn id=%0d sum=%0d", g, s);
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
        check_rsp();
    endtask

    // Call this at a negedge. The clock is still running during reset.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_rsp();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input int x, input int y, input bit c);
        req_x[i*W +: W] = W'(x);
        req_y[i*W +: W] = W'(y);
        req_cin[i]      = c;
    endtask

    initial begin
        int exp_rr [6];
        exp_rr = '{0, 1, 2, 3, 0, 1};
        rst_n     = 1'b0;
        cfg_en    = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        last_rdy  = '0;
        model_reset();
        do_reset();

        // Single requester: 200 + 100 + 1 = 301 from requester 2
        cfg_en    = 1'b1;
        rsp_ready = 1'b1;
        set_req(2, 200, 100, 1'b1);
        req_valid = 4'b0100;
        cycle();
        chk("single_sum", 32'(rsp_sum), 32'd301);
        chk("single_id",  32'(rsp_id),  32'd2);
        req_valid = '0;
        cycle();

        // Round-robin across all four requesters, starting again from 0
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 10 * i + 1, 3, 1'b0);
        req_valid = 4'b1111;
        grants.delete();
        for (int k = 0; k < 6; k++) cycle();
        for (int k = 0; k < 6; k++) begin
            if (k < grants.size()) chk("rr_order", 32'(grants[k]), 32'(exp_rr[k]));
            else chk("rr_count", 32'(grants.size()), 32'd6);
        end

        // Backpressure: result held for 3 cycles
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("bp_hold_id", 32'(rsp_id), 32'd1);
        rsp_ready = 1'b1;
        grants.delete();
        cycle();
        chk("bp_regrant", 32'(grants.size()), 32'd1);

        // Zero and carry corners on requester 0
        do_reset();
        req_valid = 4'b0001;
        set_req(0, 0, 0, 1'b0);
        cycle();
        chk("zero_sum",  32'(rsp_sum),  32'd0);
        chk("zero_flag", 32'(rsp_zero), 32'd1);
        set_req(0, 255, 255, 1'b1);
        cycle();
        chk("max_sum",  32'(rsp_sum),  32'd511);
        chk("max_flag", 32'(rsp_zero), 32'd0);

        // cfg_en gating: the pending result drains, no grants for 5 cycles
        set_req(1, 7, 8, 1'b0);
        req_valid = 4'b0011;
        cfg_en    = 1'b0;
        grants.delete();
        for (int k = 0; k < 5; k++) cycle();
        chk("gate_nogrant", 32'(grants.size()), 32'd0);
        cfg_en = 1'b1;
        cycle();
        chk("gate_first", 32'(rsp_id), 32'd1);

        // Async reset between edges while a result is held
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        cycle();
        chk("ar_pre_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(rsp_valid), 32'd0);
        chk("ar_sum",   32'(rsp_sum),   32'd0);
        chk("ar_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        grants.delete();
        cycle();
        chk("ar_first_id", 32'(rsp_id), 32'd0);

        // Randomized traffic; operands stay stable while a request waits
        req_valid = '0;
        last_rdy  = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_rdy[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_x[i*W +: W] = ($urandom_range(0, 4) == 0) ? 8'hFF : W'($urandom);
                    req_y[i*W +: W] = ($urandom_range(0, 4) == 0) ? 8'h00 : W'($urandom);
                    req_cin[i] = 1'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cfg_en    = ($urandom_range(0, 9) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
